// File: rtl/i2s_audio_tx_if.sv
// CPU-side register interface of the I2S transmitter: sample writes, enable, status.
interface i2s_audio_tx_if #(
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic          en;
    logic [31:0]   wr_data;
    logic          wr_en;
    logic          clr_status;
    logic          full;
    logic [LW-1:0] level;
    logic          overflow;
    logic          underrun;
    logic          low_water_int;

    modport master (
        output en, wr_data, wr_en, clr_status,
        input  full, level, overflow, underrun, low_water_int
    );

    modport slave (
        input  en, wr_data, wr_en, clr_status,
        output full, level, overflow, underrun, low_water_int
    );
endinterface

// File: rtl/i2s_audio_tx.sv
// 16-bit stereo I2S transmitter fed from a sample-pair FIFO.
// Optional feature macro: I2S_LOW_WATER_INT_EN (FIFO low-water pulse on low_water_int).
module i2s_audio_tx #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned SCLK_DIV   = 16,
    parameter int unsigned MCLK_DIV   = 4,
    parameter int unsigned LOW_WATER  = 4
) (
    input  logic          clk,
    input  logic          nreset,
    i2s_audio_tx_if.slave bus,
    output logic          I2S_MCLK,
    output logic          I2S_SCLK,
    output logic          I2S_LRCLK,
    output logic          I2S_SDIN
);
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned LW        = AW + 1;
    localparam int unsigned DW        = $clog2(SCLK_DIV);
    localparam int unsigned MW        = $clog2(MCLK_DIV);
    localparam int unsigned SCLK_HALF = SCLK_DIV / 2;
    localparam int unsigned MCLK_HALF = MCLK_DIV / 2;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          full_q;
    logic          overflow_q;
    logic          underrun_q;

    logic [DW-1:0] div_cnt;
    logic [5:0]    bit_cnt;
    logic [31:0]   shift_reg;
    logic [MW-1:0] mclk_cnt;
    logic          mclk_q;
    logic          sclk_q;
    logic          lrclk_q;
    logic          sdin_q;

    logic          div_wrap_c;
    logic [DW-1:0] div_next_c;
    logic [5:0]    bit_next_c;
    logic          fetch_c;
    logic          push_c;
    logic          pop_c;
    logic          data_slot_c;
    logic [LW-1:0] level_next_c;

    // Divider/slot decode and FIFO push/pop qualification.
    always_comb begin
        div_wrap_c   = (div_cnt == DW'(SCLK_DIV - 1));
        div_next_c   = div_wrap_c ? '0 : div_cnt + DW'(1);
        bit_next_c   = div_wrap_c ? bit_cnt + 6'd1 : bit_cnt;
        fetch_c      = bus.en && div_wrap_c && (bit_cnt == 6'd63);
        push_c       = bus.wr_en && !full_q;
        pop_c        = fetch_c && (level_q != '0);
        data_slot_c  = ((bit_next_c >= 6'd1)  && (bit_next_c <= 6'd16)) ||
                       ((bit_next_c >= 6'd33) && (bit_next_c <= 6'd48));
        level_next_c = level_q;
        case ({push_c, pop_c})
            2'b10:   level_next_c = level_q + LW'(1);
            2'b01:   level_next_c = level_q - LW'(1);
            default: level_next_c = level_q;
        endcase
    end

    // FIFO storage; contents need no reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // FIFO pointers, occupancy and full flag.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            level_q <= level_next_c;
            full_q  <= (level_next_c == LW'(FIFO_DEPTH));
        end
    end

    // Sticky status flags; a clear wins over a same-cycle set.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else if (bus.clr_status) begin
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (bus.wr_en && full_q)              overflow_q <= 1'b1;
            if (fetch_c && (level_q == '0))       underrun_q <= 1'b1;
        end
    end

    // MCLK divider, free-running in phase relative to SCLK while enabled.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mclk_cnt <= '0;
            mclk_q   <= 1'b0;
        end else if (!bus.en) begin
            mclk_cnt <= '0;
            mclk_q   <= 1'b0;
        end else if (mclk_cnt == MW'(MCLK_HALF - 1)) begin
            mclk_cnt <= '0;
            mclk_q   <= ~mclk_q;
        end else begin
            mclk_cnt <= mclk_cnt + MW'(1);
        end
    end

    // Frame sequencing and serialiser; data advances on the SCLK falling edge.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            sclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            sdin_q    <= 1'b0;
        end else if (!bus.en) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            sclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            sdin_q    <= 1'b0;
        end else begin
            div_cnt <= div_next_c;
            sclk_q  <= (div_next_c >= DW'(SCLK_HALF));
            if (div_wrap_c) begin
                bit_cnt <= bit_next_c;
                lrclk_q <= bit_next_c[5];
                if (fetch_c) begin
                    shift_reg <= pop_c ? mem[rd_ptr] : 32'd0;
                    sdin_q    <= 1'b0;
                end else if (data_slot_c) begin
                    sdin_q    <= shift_reg[31];
                    shift_reg <= {shift_reg[30:0], 1'b0};
                end else begin
                    sdin_q    <= 1'b0;
                end
            end
        end
    end

`ifdef I2S_LOW_WATER_INT_EN
    logic low_water_q;

    // One pulse when a pop (without compensating write) crosses LOW_WATER downward.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            low_water_q <= 1'b0;
        end else begin
            low_water_q <= pop_c && !push_c && (level_q == LW'(LOW_WATER));
        end
    end

    assign bus.low_water_int = low_water_q;
`else
    assign bus.low_water_int = 1'b0;
`endif

    assign bus.full     = full_q;
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;
    assign bus.underrun = underrun_q;
    assign I2S_MCLK     = mclk_q;
    assign I2S_SCLK     = sclk_q;
    assign I2S_LRCLK    = lrclk_q;
    assign I2S_SDIN     = sdin_q;
endmodule
